// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

   localparam int unsigned FETCH_XLEN = 32;
   localparam logic [31:0] NOP_INST   = 32'h0000_0013;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [31:0]           inst;
   } fetch_entry_t;

   // Bits needed to index 'depth' slots (at least one).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of type T with push/pop/flush and an occupancy count.
// Used both as the prefetch queue and as the in-flight request PC tracker.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned  DEPTH = 4,
   parameter type          T     = fetch_entry_t,
   localparam int unsigned PW    = ptr_w(DEPTH),
   localparam int unsigned CW    = ptr_w(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  T              data_i,
   output T              data_o,
   output logic [CW-1:0] count_o
);

   T              mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          full_c, empty_c, do_push_c, do_pop_c;

   // Pointer increment that also works for non-power-of-two depths.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_c    = (cnt_q == CW'(DEPTH));
   assign empty_c   = (cnt_q == '0);
   assign do_push_c = push_i && !full_c && !flush_i;
   assign do_pop_c  = pop_i && !empty_c && !flush_i;
   assign data_o    = mem_q[rd_q];
   assign count_o   = cnt_q;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push_c) wr_d = ptr_inc(wr_q);
         if (do_pop_c)  rd_d = ptr_inc(rd_q);
         if (do_push_c && !do_pop_c)      cnt_d = cnt_q + CW'(1);
         else if (!do_push_c && do_pop_c) cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Payload storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/fetch_unit_prefetch.sv
// Instruction-fetch front end: PC sequencer, credit-limited imem requests and a prefetch queue.
// Define FETCH_PERF_EN to add fetched/dropped/stall event counters.
module fetch_unit_prefetch
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     MAX_OUT  = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fd_valid,
   input  logic            fd_ready,
   output logic [XLEN-1:0] fd_pc,
   output logic [31:0]     fd_inst
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_dropped,
   output logic [31:0]     perf_stall
`endif
);

   localparam int unsigned QCW = ptr_w(DEPTH + 1);
   localparam int unsigned OCW = ptr_w(MAX_OUT + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
   } entry_t;

   logic [XLEN-1:0] pc_q, pc_d;
   logic [OCW-1:0]  disc_q, disc_d;
   logic [QCW-1:0]  q_count;
   logic [OCW-1:0]  out_count;
   logic [XLEN-1:0] inflight_pc;
   entry_t          q_head, q_in;
   logic            req_fire_c, rsp_keep_c, pop_c, q_empty_c;

   // Issue only while every outstanding request still has a guaranteed queue slot.
   assign imem_req_valid = rst && !redirect_valid
                           && ((32'(q_count) + 32'(out_count)) < DEPTH)
                           && (32'(out_count) < MAX_OUT);
   assign imem_req_addr  = pc_q;
   assign req_fire_c     = imem_req_valid && imem_req_ready;
   assign rsp_keep_c     = imem_rsp_valid && (disc_q == '0) && !redirect_valid;
   assign q_empty_c      = (q_count == '0);
   assign pop_c          = !q_empty_c && fd_ready && !redirect_valid;
   assign q_in           = '{pc: inflight_pc, inst: imem_rsp_data};

   assign fd_valid = !q_empty_c;
   assign fd_pc    = q_empty_c ? '0 : q_head.pc;
   assign fd_inst  = q_empty_c ? NOP_INST : q_head.inst;

   // Responses still owed to the old stream at a redirect are dropped on arrival.
   always_comb begin
      pc_d   = pc_q;
      disc_d = disc_q;
      if (redirect_valid) begin
         pc_d   = redirect_pc & ~XLEN'(3);
         disc_d = out_count - OCW'(imem_rsp_valid);
      end else begin
         if (req_fire_c) pc_d = pc_q + XLEN'(4);
         if (imem_rsp_valid && (disc_q != '0)) disc_d = disc_q - OCW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q   <= RESET_PC;
         disc_q <= '0;
      end else begin
         pc_q   <= pc_d;
         disc_q <= disc_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH),
      .T     (entry_t)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (rsp_keep_c),
      .pop_i   (pop_c),
      .data_i  (q_in),
      .data_o  (q_head),
      .count_o (q_count)
   );

   // Tracks the PC of each in-flight request; its count is the outstanding total.
   fetch_queue #(
      .DEPTH (MAX_OUT),
      .T     (logic [XLEN-1:0])
   ) u_inflight (
      .clk     (clk),
      .rst     (rst),
      .flush_i (1'b0),
      .push_i  (req_fire_c),
      .pop_i   (imem_rsp_valid),
      .data_i  (pc_q),
      .data_o  (inflight_pc),
      .count_o (out_count)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, dropped_q, stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_q <= '0;
         dropped_q <= '0;
         stall_q   <= '0;
      end else begin
         fetched_q <= fetched_q + 32'(rsp_keep_c);
         dropped_q <= dropped_q + 32'(imem_rsp_valid && !rsp_keep_c);
         stall_q   <= stall_q + 32'(fd_valid && !fd_ready);
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_dropped = dropped_q;
   assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit_prefetch.sv
// Bench for fetch_unit_prefetch: directed scenarios plus a randomized run against a
// stream-level reference (sequential PCs restarting at each redirect target).
module tb_fetch_unit_prefetch;

   localparam int unsigned MAX_OUT = 2;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fd_valid, fd_ready;
   logic [31:0] fd_pc, fd_inst;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

   fetch_unit_prefetch #(
      .XLEN(32), .DEPTH(4), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fd_valid       (fd_valid),
      .fd_ready       (fd_ready),
      .fd_pc          (fd_pc),
      .fd_inst        (fd_inst)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_dropped   (perf_dropped),
      .perf_stall     (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc, last_due;
   int          k_fd_prob, k_req_prob, k_lat_min, k_lat_max;
   logic        k_redir;
   logic [31:0] k_redir_pc;
   logic [31:0] exp_fd_pc, exp_req_pc;
   logic        prev_redir;
   mreq_t       mem_q[$];
   logic [31:0] req_log[$];
   logic [31:0] pop_log[$];
   logic        s_req_valid, s_fd_valid;
   logic [31:0] s_req_addr, s_fd_pc, s_fd_inst;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'hC3A5_0F00;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Async reset (imem resets with it), check reset outputs, release just after a rising edge.
   task automatic do_reset();
      #2;
      rst = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; fd_ready = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_fd_valid", fd_valid, 0);
      chk("rst_fd_pc", fd_pc, 32'h0);
      chk("rst_fd_inst", fd_inst, NOP);
      @(posedge clk);
      #1;
      rst = 1'b1;
      mem_q.delete(); req_log.delete(); pop_log.delete();
      cyc = 0; last_due = -1; k_redir = 1'b0;
      exp_fd_pc = 32'h0; exp_req_pc = 32'h0; prev_redir = 1'b0;
   endtask

   // One clock cycle: drive imem/decode/redirect, sample, check against the stream model.
   task automatic step();
      logic fdr, rr, redir, rsp_now;
      int   lat, due;
      @(negedge clk);
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; rsp_now = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_q[0].addr);
         mem_q.delete(0);
         rsp_now = 1'b1;
      end
      redir = k_redir; k_redir = 1'b0;
      redirect_valid = redir; redirect_pc = k_redir_pc;
      fdr = ($urandom_range(99) < k_fd_prob);
      fd_ready = fdr;
      #1;
      s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
      s_fd_valid = fd_valid; s_fd_pc = fd_pc; s_fd_inst = fd_inst;
      if (prev_redir) chk("fd_valid_after_redirect", s_fd_valid, 0);
      if (!s_fd_valid) chk("empty_inst_nop", s_fd_inst, NOP);
      if (redir) begin
         chk("req_blocked_on_redirect", s_req_valid, 0);
         exp_fd_pc  = k_redir_pc & ~32'h3;
         exp_req_pc = k_redir_pc & ~32'h3;
      end else if (s_fd_valid && fdr) begin
         chk("fd_pc_order", s_fd_pc, exp_fd_pc);
         chk("fd_inst_data", s_fd_inst, mem_word(exp_fd_pc));
         pop_log.push_back(s_fd_pc);
         exp_fd_pc += 32'd4;
      end
      rr = ($urandom_range(99) < k_req_prob);
      imem_req_ready = rr;
      if (s_req_valid && rr) begin
         chk("req_addr", s_req_addr, exp_req_pc);
         chk("outstanding_limit", (mem_q.size() + int'(rsp_now)) < MAX_OUT, 1);
         lat = $urandom_range(k_lat_max, k_lat_min);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{addr: s_req_addr, due: due});
         req_log.push_back(s_req_addr);
         exp_req_pc += 32'd4;
      end
      prev_redir = redir;
      @(posedge clk);
      cyc++;
   endtask

   initial begin
      logic got;
      int   base;
      k_redir_pc = '0;

      // 1: single-cycle memory, decode always ready
      k_fd_prob = 100; k_req_prob = 100; k_lat_min = 1; k_lat_max = 1;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         step();
         chk("t1_fd_valid", s_fd_valid, (c >= 2));
         if (c >= 2) chk("t1_fd_pc", s_fd_pc, 32'(4 * (c - 2)));
      end

      // 2: decode stalled, queue fills to capacity then issue stops
      k_fd_prob = 0;
      do_reset();
      repeat (12) step();
      chk("t2_req_stopped", s_req_valid, 0);
      chk("t2_head_pc", s_fd_pc, 32'h0);
      chk("t2_outstanding_zero", mem_q.size(), 0);
      chk("t2_reqs_issued", req_log.size(), 4);
`ifdef FETCH_PERF_EN
      #1;
      chk("t2_perf_stall", perf_stall, 32'd10);
`endif
      k_fd_prob = 100;
      repeat (10) step();
      chk("t2_pops_after_release", pop_log.size() >= 5, 1);
      for (int i = 0; i < 5; i++) chk("t2_release_order", pop_log[i], 32'(4 * i));

      // 3: latency 3, redirect with two requests in flight
      k_lat_min = 3; k_lat_max = 3;
      do_reset();
      repeat (2) step();
      chk("t3_two_in_flight", mem_q.size(), 2);
      k_redir = 1'b1; k_redir_pc = 32'h100;
      step();
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step();
         if (s_fd_valid) begin
            got = 1'b1;
            chk("t3_first_pc_after_redirect", s_fd_pc, 32'h100);
         end
      end
      chk("t3_fd_valid_seen", got, 1);
`ifdef FETCH_PERF_EN
      #1;
      chk("t3_perf_dropped", perf_dropped, 32'd2);
`endif

      // 4: unaligned target; redirect coinciding with a pop and a response
      k_lat_min = 1; k_lat_max = 1;
      do_reset();
      repeat (4) step();
      k_redir = 1'b1; k_redir_pc = 32'h203;
      step();
      chk("t4_pop_pending_at_redirect", s_fd_valid, 1);
      step();
      chk("t4_req_at_r1", s_req_valid, 1);
      chk("t4_req_addr_aligned", s_req_addr, 32'h200);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         step();
         if (s_fd_valid) begin
            got = 1'b1;
            chk("t4_first_pc", s_fd_pc, 32'h200);
         end
      end
      chk("t4_fd_valid_seen", got, 1);

      // 5: PC wrap, then reset in the middle of a burst
      k_redir = 1'b1; k_redir_pc = 32'hFFFF_FFF8;
      step();
      base = req_log.size();
      repeat (6) step();
      chk("t5_reqs_after_wrap", req_log.size() >= base + 3, 1);
      chk("t5_addr_fff8", req_log[base], 32'hFFFF_FFF8);
      chk("t5_addr_fffc", req_log[base + 1], 32'hFFFF_FFFC);
      chk("t5_addr_wrap", req_log[base + 2], 32'h0);
      do_reset();

      // Randomized traffic with occasional (sometimes back-to-back) redirects
      k_fd_prob = 70; k_req_prob = 70; k_lat_min = 1; k_lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < (prev_redir ? 30 : 3)) begin
            k_redir = 1'b1;
            k_redir_pc = $urandom();
         end
         step();
      end
      chk("random_progress", pop_log.size() > 200, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
